// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder
//  Purpose  : Single-bit full-adder cell (sum and carry of three input bits).
//  Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Plain combinational sum and majority carry
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder. Captures two operands and a carry-in,
//             feeds one bit pair per clock (LSB first) through a full-adder
//             cell with a recirculating carry flop, then presents the parallel
//             sum and carry-out together with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter wide enough to reach WIDTH itself after the final bit.
    localparam int            CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ss;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_co;
    logic [WIDTH-1:0] w_ss_next;
    logic             w_last;

    // One bit position per clock: LSBs of the operand shifters plus the carry flop
    full_adder u_fa (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .ci (r_c),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at bit 0
    always_comb begin
        w_ss_next = {w_fa_s, r_ss[WIDTH-1:1]};
        w_last    = (r_cnt == c_cnt_last);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs derived from state
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result latch on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_ss   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_c   <= cin;
                        r_cnt <= '0;
                    end
                end
                S_ADD: begin
                    r_ss  <= w_ss_next;
                    r_c   <= w_fa_co;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + c_cnt_one;
                    // Outputs only ever change here, so partial sums stay hidden
                    if (w_last) begin
                        r_sum  <= w_ss_next;
                        r_cout <= w_fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered results drive the outputs directly
    always_comb begin
        sum  = r_sum;
        cout = r_cout;
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W  = 8;
    localparam int W3 = 3;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, cin, busy, done, cout;
    logic [W-1:0] a, b, sum;

    logic          rst3, start3, cin3, busy3, done3, cout3;
    logic [W3-1:0] a3, b3, sum3;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(W3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the addition itself in WIDTH+1 bit arithmetic
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Entered #1 after a rising edge with the DUT idle; leaves the DUT idle.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           output int lat, output logic busy_e,
                           output logic [7:0] rs, output logic rc, output int dwidth);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        busy_e = busy;
        lat    = -1;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        rs     = sum;
        rc     = cout;
        dwidth = 0;
        if (lat >= 0) begin
            dwidth = 1;
            @(posedge clk); #1;
            if (done) dwidth = 2;
        end
    endtask

    initial begin
        int         lat, dw, ndone, dcyc[$];
        logic       be, rc;
        logic [7:0] rs;
        logic [8:0] exp9;
        logic [7:0] qa, qb;
        logic       qc;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rst3 = 1'b0;

        // Directed table
        for (int i = 0; i < 3; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, be, rs, rc, dw);
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_busy",    32'(be),  32'd1);
            check("vec_sum",     32'(rs),  32'(vecs[i].sum));
            check("vec_cout",    32'(rc),  32'(vecs[i].cout));
            check("vec_donew",   32'(dw),  32'd1);
        end

        // Non-zero result, then asynchronous reset mid-cycle
        run_add(8'hC8, 8'h64, 1'b1, lat, be, rs, rc, dw);
        check("pre_rst_sum",  32'(rs), 32'h2D);
        check("pre_rst_cout", 32'(rc), 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_sum",  32'(sum),  32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ignored start pulses and operand changes after capture
        a = 8'h77; b = 8'h19; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        ndone = 0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            start = (cyc == 2 || cyc == 5);
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("ign_done_cycle", 32'(cyc), 32'd8);
                check("ign_sum", 32'(sum), 32'h90);
            end
        end
        start = 1'b0;
        check("ign_ndone",     32'(ndone), 32'd1);
        check("ign_sum_held",  32'(sum),   32'h90);
        check("ign_cout_held", 32'(cout),  32'd0);

        // Reset during ADD cycle 4
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midop_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midop_busy", 32'(busy), 32'd0);
        check("midop_done", 32'(done), 32'd0);
        check("midop_sum",  32'(sum),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midop_no_done", 32'(ndone), 32'd0);
        run_add(8'h12, 8'h34, 1'b0, lat, be, rs, rc, dw);
        check("midop_retry_sum",  32'(rs),  32'h46);
        check("midop_retry_cout", 32'(rc),  32'd0);
        check("midop_retry_lat",  32'(lat), 32'd8);

        // Back-to-back with start held high
        qa = 8'($urandom); qb = 8'($urandom); qc = 1'($urandom);
        a = qa; b = qb; cin = qc; start = 1'b1;
        for (int cyc = 0; cyc < 45 && dcyc.size() < 3; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                dcyc.push_back(cyc);
                exp9 = model(qa, qb, qc);
                check("b2b_sum",  32'(sum),  32'(exp9[7:0]));
                check("b2b_cout", 32'(cout), 32'(exp9[8]));
                qa = 8'($urandom); qb = 8'($urandom); qc = 1'($urandom);
                a = qa; b = qb; cin = qc;
                if (dcyc.size() == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_npulses", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            check("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd10);
            check("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd10);
        end
        @(posedge clk); #1;

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            qa = 8'($urandom); qb = 8'($urandom); qc = 1'($urandom);
            run_add(qa, qb, qc, lat, be, rs, rc, dw);
            exp9 = model(qa, qb, qc);
            check("rnd_sum",  32'(rs),  32'(exp9[7:0]));
            check("rnd_cout", 32'(rc),  32'(exp9[8]));
            check("rnd_lat",  32'(lat), 32'd8);
        end

        // Exhaustive WIDTH=3
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                for (int c = 0; c < 2; c++) begin
                    a3 = 3'(x); b3 = 3'(y); cin3 = 1'(c); start3 = 1'b1;
                    @(posedge clk); #1;
                    start3 = 1'b0;
                    lat = -1;
                    for (int k = 1; k <= W3 + 4; k++) begin
                        @(posedge clk); #1;
                        if (done3) begin
                            lat = k;
                            break;
                        end
                    end
                    check("w3_result", 32'({cout3, sum3}), 32'(x + y + c));
                    check("w3_lat", 32'(lat), 32'd3);
                    @(posedge clk); #1;
                    check("w3_donew", 32'(done3), 32'd0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
